// File: rtl/fle_ff_pipe_bank.sv
// fle_ff_pipe_bank: WIDTH-bit register bank, DEPTH stages deep.
//
// Replaces chains of single-bit fabric ff primitives when retiming registers are
// mapped. Stage 0 can work as a plain DFF or as a toggle register (stage0 ^= D).
// Downstream stages always shift normally. A saturating fill counter drives
// ff_primed once DEPTH enabled captures have happened since reset.
//
// Edge priority: set > scan shift > ff_ce > hold.
//
// Optional feature macro: FF_SCAN_EN
//   When defined, adds a serial scan chain of WIDTH*DEPTH bits:
//   scan_in -> stage[0][0] .. stage[0][WIDTH-1] -> stage[1][0] .. -> scan_out.
//   When undefined, the scan ports and scan logic are absent.
//
// Parameters:
//   WIDTH  data bits per stage (>= 1)
//   DEPTH  pipeline stages (>= 1); latency is DEPTH enabled cycles
//   CNT_W  fill counter width, derived as $clog2(DEPTH+1)
//
// Ports:
//   clk        rising-edge fabric clock
//   reset      asynchronous active-high reset (clears stages, counter)
//   set        synchronous active-high set (stages all ones, counter full)
//   ff_D       data into stage 0
//   ff_ce      clock enable for data advance
//   ff_mode    0 = DFF, 1 = toggle on stage 0
//   ff_Q       contents of stage DEPTH-1
//   ff_primed  high once the pipeline holds DEPTH enabled captures
//   scan_en    scan shift enable          (FF_SCAN_EN only)
//   scan_in    serial scan input          (FF_SCAN_EN only)
//   scan_out   serial scan output         (FF_SCAN_EN only)

module fle_ff_pipe_bank #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic [WIDTH-1:0] ff_D,
  input  logic             ff_ce,
  input  logic             ff_mode,
  output logic [WIDTH-1:0] ff_Q,
  output logic             ff_primed
`ifdef FF_SCAN_EN
  ,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out
`endif
);

  localparam int unsigned BITS = WIDTH * DEPTH;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEPTH);

  // Stage i occupies bits [i*WIDTH +: WIDTH]; this flat layout is also the
  // scan chain order, so a scan shift is a one-bit left shift of the vector.
  logic [BITS-1:0]  stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (set) begin
      stage_d = '1;
      cnt_d   = CntMax;
    end
`ifdef FF_SCAN_EN
    else if (scan_en) begin
      stage_d[0] = scan_in;
      for (int k = 1; k < int'(BITS); k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
`endif
    else if (ff_ce) begin
      stage_d[WIDTH-1:0] = ff_mode ? (stage_q[WIDTH-1:0] ^ ff_D) : ff_D;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_d[i*WIDTH +: WIDTH] = stage_q[(i-1)*WIDTH +: WIDTH];
      end
      // Saturate so ff_primed never drops back through a wrap.
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ff_Q      = stage_q[(DEPTH-1)*WIDTH +: WIDTH];
  assign ff_primed = (cnt_q == CntMax);

`ifdef FF_SCAN_EN
  assign scan_out = stage_q[BITS-1];
`endif

endmodule

// File: tb/tb_fle_ff_pipe_bank.sv
// Self-checking bench for fle_ff_pipe_bank: a WIDTH=4/DEPTH=2 instance driven
// from a vector table, plus hand-written sequences for async reset, a DEPTH=3
// instance (latency and counter saturation) and, when FF_SCAN_EN is defined,
// the scan chain.

module tb_fle_ff_pipe_bank;

  logic       clk = 1'b0;
  logic       reset, set, ff_ce, ff_mode;
  logic [3:0] ff_D, ff_Q;
  logic       ff_primed;

  logic       reset3, set3, ce3;
  logic [3:0] d3, q3;
  logic       primed3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

`ifdef FF_SCAN_EN
  logic scan_en, scan_in, scan_out;
  logic scan_en3, scan_in3, scan_out3;
`endif

  fle_ff_pipe_bank #(.WIDTH(4), .DEPTH(2)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .set       (set),
    .ff_D      (ff_D),
    .ff_ce     (ff_ce),
    .ff_mode   (ff_mode),
    .ff_Q      (ff_Q),
    .ff_primed (ff_primed)
`ifdef FF_SCAN_EN
    ,
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .scan_out  (scan_out)
`endif
  );

  fle_ff_pipe_bank #(.WIDTH(4), .DEPTH(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset3),
    .set       (set3),
    .ff_D      (d3),
    .ff_ce     (ce3),
    .ff_mode   (1'b0),
    .ff_Q      (q3),
    .ff_primed (primed3)
`ifdef FF_SCAN_EN
    ,
    .scan_en   (scan_en3),
    .scan_in   (scan_in3),
    .scan_out  (scan_out3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       rst;
    logic       set;
    logic       ce;
    logic       mode;
    logic [3:0] d;
    logic [3:0] q;
    logic       p;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  initial begin
    //            rst   set   ce    mode  d      q      p
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 4'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 4'hA, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h9, 4'h0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 4'h0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h9, 4'h0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h6, 4'h3, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h6, 4'h6, 1'b1}; // stage0 = 6^6 = 0
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 4'h0, 1'b0}; // stage0 1
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 4'h1, 1'b1}; // stage0 0
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 4'h0, 1'b1}; // stage0 1
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 4'h0, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 4'hF, 1'b1}; // stage0 F^1 = E
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 4'hE, 1'b1};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h7, 4'hF, 1'b1};
  end

  initial begin
    logic [3:0] exp_q3;
    reset = 1'b1; set = 1'b0; ff_ce = 1'b0; ff_mode = 1'b0; ff_D = 4'h0;
    reset3 = 1'b1; set3 = 1'b0; ce3 = 1'b0; d3 = 4'h0;
`ifdef FF_SCAN_EN
    scan_en = 1'b0; scan_in = 1'b0; scan_en3 = 1'b0; scan_in3 = 1'b0;
`endif
    #1;

    // Table-driven vectors on the DEPTH=2 instance.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (vecs[i].rst) begin
        set = 1'b0; ff_ce = 1'b0; ff_D = 4'h0; ff_mode = 1'b0;
        reset = 1'b1;
        #1;
        check($sformatf("v%0d rst q", i), 32'(ff_Q), 32'(vecs[i].q));
        check($sformatf("v%0d rst primed", i), 32'(ff_primed), 32'(vecs[i].p));
        @(posedge clk);
        #1;
        reset = 1'b0;
      end else begin
        set = vecs[i].set; ff_ce = vecs[i].ce; ff_mode = vecs[i].mode; ff_D = vecs[i].d;
        @(posedge clk);
        #1;
        check($sformatf("v%0d q", i), 32'(ff_Q), 32'(vecs[i].q));
        check($sformatf("v%0d primed", i), 32'(ff_primed), 32'(vecs[i].p));
      end
    end

    // Asynchronous reset mid-cycle: outputs drop before the next edge.
    set = 1'b0; ff_ce = 1'b1; ff_D = 4'h5;
    #2;
    reset = 1'b1;
    #1;
    check("async rst q", 32'(ff_Q), 32'h0);
    check("async rst primed", 32'(ff_primed), 32'h0);
    @(posedge clk);
    #1;
    check("rst held over ce edge q", 32'(ff_Q), 32'h0);
    check("rst held over ce edge primed", 32'(ff_primed), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    ff_ce = 1'b0;

    // DEPTH=3: latency of three enabled edges, counter saturates at DEPTH.
    @(negedge clk);
    reset3 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      ce3 = 1'b1; d3 = 4'(k);
      @(posedge clk);
      #1;
      exp_q3 = (k >= 3) ? 4'(k - 2) : 4'h0;
      check($sformatf("d3 edge%0d q", k), 32'(q3), 32'(exp_q3));
      check($sformatf("d3 edge%0d primed", k), 32'(primed3), (k >= 3) ? 32'h1 : 32'h0);
    end
    // Stall stretches latency without losing data.
    @(negedge clk);
    ce3 = 1'b0; d3 = 4'hC;
    repeat (2) @(posedge clk);
    #1;
    check("d3 stall q", 32'(q3), 32'h8);
    @(negedge clk);
    ce3 = 1'b1; d3 = 4'hC;
    @(posedge clk);
    #1;
    check("d3 after stall q", 32'(q3), 32'h9);

    // Set with a partly filled pipeline makes it primed on the next edge.
    @(negedge clk);
    ce3 = 1'b0;
    reset3 = 1'b1;
    #1;
    check("d3 rst primed", 32'(primed3), 32'h0);
    @(negedge clk);
    reset3 = 1'b0; ce3 = 1'b1; d3 = 4'h2;
    @(posedge clk);
    #1;
    check("d3 one capture primed", 32'(primed3), 32'h0);
    @(negedge clk);
    set3 = 1'b1; ce3 = 1'b0;
    @(posedge clk);
    #1;
    check("d3 set primed", 32'(primed3), 32'h1);
    check("d3 set q", 32'(q3), 32'hF);
    @(negedge clk);
    set3 = 1'b0;

`ifdef FF_SCAN_EN
    // Load chain = {stage1, stage0} = 8'hA5, then shift 1,0,0,0,0,0,0,1 with ce=0.
    begin
      logic [7:0] old_chain;
      logic [7:0] in_bits;
      old_chain = 8'hA5;
      in_bits   = 8'b1000_0001; // bit 7 is shifted first
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; ff_ce = 1'b1; ff_mode = 1'b0; ff_D = 4'hA;
      @(negedge clk);
      ff_D = 4'h5;
      @(negedge clk);
      ff_ce = 1'b0;
      for (int b = 7; b >= 0; b--) begin
        check($sformatf("scan_out bit%0d", b), 32'(scan_out), 32'(old_chain[b]));
        scan_en = 1'b1; scan_in = in_bits[b];
        @(posedge clk);
        #1;
        @(negedge clk);
      end
      scan_en = 1'b0;
      check("scan final q", 32'(ff_Q), 32'h8);
      check("scan final primed", 32'(ff_primed), 32'h1);
      // Set beats scan.
      set = 1'b1; scan_en = 1'b1; scan_in = 1'b0;
      @(posedge clk);
      #1;
      check("set over scan q", 32'(ff_Q), 32'hF);
      @(negedge clk);
      set = 1'b0; scan_en = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
